// File: rtl/if_id_pipe_pkg.sv
// Shared definitions for the IF/ID pipeline register: control encodings,
// FSM states and the per-edge action decode.
package if_id_pipe_pkg;

    localparam logic        Stop      = 1'b1;
    localparam logic        NoStop    = 1'b0;
    localparam logic        RstEnable = 1'b1;
    localparam logic [31:0] ZeroWord  = 32'h0000_0000;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } pipe_state_e;

    typedef enum logic [1:0] {
        ACT_FLUSH   = 2'd0,
        ACT_BUBBLE  = 2'd1,
        ACT_HOLD    = 2'd2,
        ACT_ADVANCE = 2'd3
    } pipe_action_e;

    // Flush beats any stall; a stalled stage bubbles unless downstream is also stopped.
    function automatic pipe_action_e decode_action(input logic flush,
                                                   input logic own_stall,
                                                   input logic next_stall);
        pipe_action_e act;
        act = ACT_ADVANCE;
        if (flush) begin
            act = ACT_FLUSH;
        end else if (own_stall == Stop) begin
            act = (next_stall == Stop) ? ACT_HOLD : ACT_BUBBLE;
        end
        return act;
    endfunction

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear outranks increment.
module pipe_sat_cnt
    import if_id_pipe_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {W{1'b1}})) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/if_id_pipe.sv
// IF/ID pipeline register with flush/bubble/hold control, bubble and hold
// performance counters, and a consecutive-hold timeout flag.
module if_id_pipe
    import if_id_pipe_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int INST_W  = 32,
    parameter int LANES   = 1,
    parameter int STALL_W = 6,
    parameter int STAGE   = 1,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [STALL_W-1:0]        stall,
    input  logic                      flush,
    input  logic [LANES*ADDR_W-1:0]   if_pc,
    input  logic [LANES*INST_W-1:0]   if_inst,
    input  logic [LANES-1:0]          if_valid,
    output logic [LANES*ADDR_W-1:0]   id_pc,
    output logic [LANES*INST_W-1:0]   id_inst,
    output logic [LANES-1:0]          id_valid,
    output logic [CNT_W-1:0]          bubble_cnt,
    output logic [CNT_W-1:0]          hold_cnt,
    output logic                      stall_timeout
);

    localparam int LEN_W = CNT_W + 2;

    pipe_state_e               state_reg, state_next;
    pipe_action_e              action;
    logic [LANES*ADDR_W-1:0]   pc_reg, pc_next;
    logic [LANES*INST_W-1:0]   inst_reg, inst_next;
    logic [LANES-1:0]          valid_reg, valid_next;
    logic                      timeout_reg, timeout_next;
    logic [LANES*INST_W-1:0]   adv_inst;
    logic [CNT_W-1:0]          run_len;
    logic [LEN_W-1:0]          hold_len;
    logic                      run_clr, run_inc;
    logic                      stall_unused;

    // Only our own bit and the downstream bit steer this stage.
    assign stall_unused = &{1'b0, stall};

    assign action = decode_action(flush, stall[STAGE], stall[STAGE+1]);

    // Invalid lanes forward a zero instruction so ID never decodes stale bits.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign adv_inst[gi*INST_W +: INST_W] =
            if_valid[gi] ? if_inst[gi*INST_W +: INST_W] : {INST_W{1'b0}};
    end

    // Consecutive hold cycles including the one being taken on this edge.
    assign hold_len = (state_reg == HOLD) ? ({2'b00, run_len} + LEN_W'(2)) : LEN_W'(1);

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        inst_next    = inst_reg;
        valid_next   = valid_reg;
        timeout_next = 1'b0;
        case (action)
            ACT_FLUSH, ACT_BUBBLE: begin
                state_next = RUN;
                pc_next    = '0;
                inst_next  = '0;
                valid_next = '0;
            end
            ACT_HOLD: begin
                state_next   = HOLD;
                timeout_next = timeout_reg || (hold_len >= LEN_W'(TIMEOUT));
            end
            default: begin
                state_next = RUN;
                pc_next    = if_pc;
                inst_next  = adv_inst;
                valid_next = if_valid;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_reg   <= RUN;
            pc_reg      <= '0;
            inst_reg    <= '0;
            valid_reg   <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            inst_reg    <= inst_next;
            valid_reg   <= valid_next;
            timeout_reg <= timeout_next;
        end
    end

    // Run length restarts at zero on the first hold edge and on any exit from HOLD.
    assign run_clr = (action != ACT_HOLD) || (state_reg == RUN);
    assign run_inc = (action == ACT_HOLD) && (state_reg == HOLD);

    pipe_sat_cnt #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (action == ACT_BUBBLE),
        .count (bubble_cnt)
    );

    pipe_sat_cnt #(.W(CNT_W)) u_hold_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (action == ACT_HOLD),
        .count (hold_cnt)
    );

    pipe_sat_cnt #(.W(CNT_W)) u_run_len (
        .clk   (clk),
        .rst   (rst),
        .clr   (run_clr),
        .inc   (run_inc),
        .count (run_len)
    );

    assign id_pc         = pc_reg;
    assign id_inst       = inst_reg;
    assign id_valid      = valid_reg;
    assign stall_timeout = timeout_reg;

endmodule

// File: tb/tb_if_id_pipe.sv
// Scoreboard bench: directed steps push hand-computed expectations, a monitor
// pops and compares after each clock edge. Instance A is default, B is 2-lane.
module tb_if_id_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b1, rst_b = 1'b1;
    logic [5:0]  stall = '0;
    logic        flush = 1'b0;
    logic [31:0] if_pc_a = '0, if_inst_a = '0;
    logic [0:0]  if_valid_a = '0;
    logic [63:0] if_pc_b = '0, if_inst_b = '0;
    logic [1:0]  if_valid_b = '0;

    logic [31:0] id_pc_a, id_inst_a;
    logic [0:0]  id_valid_a;
    logic [15:0] bubble_a, hold_a;
    logic        tmo_a;
    logic [63:0] id_pc_b, id_inst_b;
    logic [1:0]  id_valid_b;
    logic [3:0]  bubble_b, hold_b;
    logic        tmo_b;

    if_id_pipe dut_a (
        .clk(clk), .rst(rst_a), .stall(stall), .flush(flush),
        .if_pc(if_pc_a), .if_inst(if_inst_a), .if_valid(if_valid_a),
        .id_pc(id_pc_a), .id_inst(id_inst_a), .id_valid(id_valid_a),
        .bubble_cnt(bubble_a), .hold_cnt(hold_a), .stall_timeout(tmo_a)
    );

    if_id_pipe #(.LANES(2), .CNT_W(4), .TIMEOUT(4)) dut_b (
        .clk(clk), .rst(rst_b), .stall(stall), .flush(flush),
        .if_pc(if_pc_b), .if_inst(if_inst_b), .if_valid(if_valid_b),
        .id_pc(id_pc_b), .id_inst(id_inst_b), .id_valid(id_valid_b),
        .bubble_cnt(bubble_b), .hold_cnt(hold_b), .stall_timeout(tmo_b)
    );

    typedef struct {
        logic        sel;
        string       name;
        logic [63:0] pc;
        logic [63:0] inst;
        logic [1:0]  valid;
        logic [15:0] bub;
        logic [15:0] hld;
        logic        tmo;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic step(input logic sel, input string nm, input logic r,
                        input logic [5:0] st, input logic f,
                        input logic [63:0] pc, input logic [63:0] inst,
                        input logic [1:0] v,
                        input logic [63:0] epc, input logic [63:0] einst,
                        input logic [1:0] ev, input logic [15:0] eb,
                        input logic [15:0] eh, input logic et);
        exp_t e;
        @(negedge clk);
        stall = st;
        flush = f;
        if (sel == 1'b0) begin
            rst_a = r; if_pc_a = pc[31:0]; if_inst_a = inst[31:0]; if_valid_a = v[0:0];
        end else begin
            rst_b = r; if_pc_b = pc; if_inst_b = inst; if_valid_b = v;
        end
        e.sel = sel; e.name = nm; e.pc = epc; e.inst = einst; e.valid = ev;
        e.bub = eb; e.hld = eh; e.tmo = et;
        exp_q.push_back(e);
    endtask

    // Monitor: compare every DUT output presented after the edge each entry targets.
    initial begin
        exp_t e;
        logic [63:0] apc, ainst;
        logic [1:0]  av;
        logic [15:0] ab, ah;
        logic        at;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.sel == 1'b0) begin
                    apc = {32'h0, id_pc_a}; ainst = {32'h0, id_inst_a}; av = {1'b0, id_valid_a};
                    ab = bubble_a; ah = hold_a; at = tmo_a;
                end else begin
                    apc = id_pc_b; ainst = id_inst_b; av = id_valid_b;
                    ab = {12'h0, bubble_b}; ah = {12'h0, hold_b}; at = tmo_b;
                end
                checks++;
                if (apc !== e.pc || ainst !== e.inst || av !== e.valid ||
                    ab !== e.bub || ah !== e.hld || at !== e.tmo) begin
                    errors++;
                    $display("FAIL %s: got pc=%h inst=%h v=%b bub=%0d hold=%0d tmo=%b, want pc=%h inst=%h v=%b bub=%0d hold=%0d tmo=%b",
                             e.name, apc, ainst, av, ab, ah, at,
                             e.pc, e.inst, e.valid, e.bub, e.hld, e.tmo);
                end else begin
                    $display("txn %s ok: pc=%h inst=%h v=%b bub=%0d hold=%0d tmo=%b",
                             e.name, apc, ainst, av, ab, ah, at);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required end before 200000");
        $fatal(1, "watchdog");
    end

    localparam logic [5:0] S_RUN = 6'b000000;
    localparam logic [5:0] S_BUB = 6'b000010;
    localparam logic [5:0] S_HLD = 6'b000110;

    initial begin
        // ---------------- instance A: LANES=1, CNT_W=16, TIMEOUT=64 ----------------
        step(0, "a_reset", 1, S_RUN, 0, 64'h40, 64'h3C01_0001, 2'b01, 0, 0, 0, 0, 0, 0);
        step(0, "a_load", 0, S_RUN, 0, 64'h40, 64'h3C01_0001, 2'b01,
             64'h40, 64'h3C01_0001, 2'b01, 0, 0, 0);
        step(0, "a_invalid_zero_inst", 0, S_RUN, 0, 64'h44, 64'hDEAD, 2'b00,
             64'h44, 64'h0, 2'b00, 0, 0, 0);
        for (int i = 1; i <= 3; i++)
            step(0, $sformatf("a_bubble%0d", i), 0, S_BUB, 0, 64'h48, 64'h1234, 2'b01,
                 0, 0, 0, 16'(i), 0, 0);
        step(0, "a_load2", 0, S_RUN, 0, 64'h80, 64'h1111_2222, 2'b01,
             64'h80, 64'h1111_2222, 2'b01, 3, 0, 0);
        for (int i = 1; i <= 5; i++)
            step(0, $sformatf("a_hold%0d", i), 0, S_HLD, 0, 64'h99, 64'hFFFF, 2'b01,
                 64'h80, 64'h1111_2222, 2'b01, 3, 16'(i), 0);
        step(0, "a_ignored_bits", 0, 6'b111001, 0, 64'h100, 64'h55, 2'b01,
             64'h100, 64'h55, 2'b01, 3, 5, 0);
        step(0, "a_flush_over_hold", 0, S_HLD, 1, 64'h104, 64'h66, 2'b01,
             0, 0, 0, 3, 5, 0);
        step(0, "a_bubble_bit3", 0, 6'b001010, 0, 64'h108, 64'h77, 2'b01,
             0, 0, 0, 4, 5, 0);

        // ---------------- instance B: LANES=2, CNT_W=4, TIMEOUT=4 ----------------
        step(1, "b_reset", 1, S_RUN, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        step(1, "b_load", 0, S_RUN, 0, 64'h0000_0204_0000_0200, 64'h0000_BBBB_0000_AAAA, 2'b11,
             64'h0000_0204_0000_0200, 64'h0000_BBBB_0000_AAAA, 2'b11, 0, 0, 0);
        for (int i = 1; i <= 6; i++)
            step(1, $sformatf("b_hold%0d", i), 0, S_HLD, 0, 64'h1, 64'h2, 2'b00,
                 64'h0000_0204_0000_0200, 64'h0000_BBBB_0000_AAAA, 2'b11, 0, 16'(i), (i >= 4));
        step(1, "b_release", 0, S_RUN, 0, 64'h0000_020C_0000_0208, 64'h0000_000D_0000_000C, 2'b01,
             64'h0000_020C_0000_0208, 64'h0000_0000_0000_000C, 2'b01, 0, 6, 0);
        step(1, "b_flush_with_hold", 0, S_HLD, 1, 64'h0000_0304_0000_0300, 64'h0000_2222_0000_1111, 2'b10,
             0, 0, 0, 0, 6, 0);
        step(1, "b_lane1_only", 0, S_RUN, 0, 64'h0000_0304_0000_0300, 64'h0000_2222_0000_1111, 2'b10,
             64'h0000_0304_0000_0300, 64'h0000_2222_0000_0000, 2'b10, 0, 6, 0);
        for (int i = 1; i <= 4; i++)
            step(1, $sformatf("b_hold_again%0d", i), 0, S_HLD, 0, 64'h5, 64'h6, 2'b11,
                 64'h0000_0304_0000_0300, 64'h0000_2222_0000_0000, 2'b10, 0, 16'(6 + i), (i == 4));
        step(1, "b_flush_clears_timeout", 0, S_HLD, 1, 64'h5, 64'h6, 2'b11,
             0, 0, 0, 0, 10, 0);
        for (int i = 1; i <= 20; i++)
            step(1, $sformatf("b_bubble%0d", i), 0, S_BUB, 0, 64'h7, 64'h8, 2'b11,
                 0, 0, 0, (i > 15) ? 16'd15 : 16'(i), 10, 0);
        step(1, "b_hold_pre_rst1", 0, S_HLD, 0, 64'h7, 64'h8, 2'b11, 0, 0, 0, 15, 11, 0);
        step(1, "b_hold_pre_rst2", 0, S_HLD, 0, 64'h7, 64'h8, 2'b11, 0, 0, 0, 15, 12, 0);
        step(1, "b_rst_mid_hold", 1, S_HLD, 0, 64'h7, 64'h8, 2'b11, 0, 0, 0, 0, 0, 0);
        step(1, "b_post_rst_hold", 0, S_HLD, 0, 64'h7, 64'h8, 2'b11, 0, 0, 0, 0, 1, 0);
        step(1, "b_post_rst_load", 0, S_RUN, 0, 64'h0000_0404_0000_0400, 64'h0000_0004_0000_0003, 2'b11,
             64'h0000_0404_0000_0400, 64'h0000_0004_0000_0003, 2'b11, 0, 1, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_pipe.md
IF_ID_PIPE -- requirements
Module: if_id_pipe

Interface
REQ-001 Parameter ADDR_W, default 32, PC width per lane.
REQ-002 Parameter INST_W, default 32, instruction width per lane.
REQ-003 Parameter LANES, default 1, issue lanes, legal range 1..4.
REQ-004 Parameter STALL_W, default 6, stall vector width.
REQ-005 Parameter STAGE, default 1, own stall bit; downstream bit is STAGE+1; STAGE+1 < STALL_W.
REQ-006 Parameter CNT_W, default 16, performance-counter width.
REQ-007 Parameter TIMEOUT, default 64, consecutive-hold threshold, 1..2^CNT_W-1.
REQ-008 Clocking: one clock; reset is synchronous and active-high.
REQ-009 clk  in  1  sole clock, rising edge.
REQ-010 rst  in  1  synchronous reset, active-high.
REQ-011 stall  in  STALL_W  pipeline stall vector, 1 = stop.
REQ-012 flush  in  1  exception/branch flush of this stage.
REQ-013 if_pc  in  LANES*ADDR_W  fetch PCs, lane 0 in LSBs.
REQ-014 if_inst  in  LANES*INST_W  fetch instructions, lane 0 in LSBs.
REQ-015 if_valid  in  LANES  per-lane fetch valid.
REQ-016 id_pc  out  LANES*ADDR_W  registered PCs.
REQ-017 id_inst  out  LANES*INST_W  registered instructions.
REQ-018 id_valid  out  LANES  registered per-lane valid.
REQ-019 bubble_cnt  out  CNT_W  saturating count of bubbles inserted.
REQ-020 hold_cnt  out  CNT_W  saturating count of hold cycles.
REQ-021 stall_timeout  out  1  consecutive hold reached TIMEOUT.

Function
REQ-022 All outputs registered; one-cycle latency from if_* to id_*.
REQ-023 Per rising edge the action is chosen by strict priority: rst, flush, bubble, hold, advance.
REQ-024 Flush: id_pc, id_inst, id_valid cleared to zero; counters unchanged; FSM to RUN.
REQ-025 Bubble (stall[STAGE]=1, stall[STAGE+1]=0): id_* cleared to zero; bubble_cnt +1.
REQ-026 Hold (stall[STAGE]=1, stall[STAGE+1]=1): id_* keep their values; hold_cnt +1.
REQ-027 Advance (stall[STAGE]=0): per lane k, id_pc/id_valid take if_pc/if_valid; id_inst takes if_inst if if_valid[k]=1, else zero.
REQ-028 Stall bits other than STAGE and STAGE+1 are ignored.
REQ-029 Counters saturate at all-ones and never wrap.
REQ-030 FSM states RUN and HOLD; RUN->HOLD on a hold cycle; HOLD stays on hold; HOLD->RUN on flush, bubble or advance.
REQ-031 A run-length counter clears on entering HOLD's first cycle then increments each further hold cycle; it clears on leaving HOLD.
REQ-032 stall_timeout registered; asserted from the edge where consecutive hold cycles reach TIMEOUT; deasserted on the edge leaving HOLD.
REQ-033 Flush and stall in the same cycle: flush wins, no counter increments.

Reset
REQ-034 Reset clears id_pc, id_inst, id_valid, bubble_cnt, hold_cnt, stall_timeout and run length; FSM to RUN.
REQ-035 Reset mid-hold or mid-timeout clears everything on that edge; the first post-reset cycle acts on live inputs.

Structure
REQ-036 Stop/NoStop, RstEnable, ZeroWord, and the RUN/HOLD encodings live in the shared defines package.
REQ-037 One sub-module, pipe_sat_cnt (parametrised width, inc, clr, saturating), instantiated for bubble_cnt, hold_cnt and run length.

Verification
REQ-038 LANES=1: if_pc=0x0000_0040, inst=0x3C01_0001, valid=1, stall=0 -> next edge id_pc=0x40, id_inst=0x3C010001, id_valid=1.
REQ-039 stall=6'b000010 for 3 cycles -> id_* zero for all 3; bubble_cnt=3.
REQ-040 stall=6'b000110 for 5 cycles after a valid load -> id_* unchanged; hold_cnt=5; stall_timeout=0.
REQ-041 TIMEOUT=4, hold for 6 cycles then stall=0 -> stall_timeout rises on the 4th hold edge and falls on the release edge.
REQ-042 LANES=2, if_valid=2'b10, flush=1 with stall=6'b000110 -> id_* zero; counters unchanged; next cycle advance gives lane0 inst=0, lane1 captured.
REQ-043 CNT_W=4, 20 bubble cycles -> bubble_cnt holds 0xF; rst=1 -> all outputs zero next edge.
